// File: rtl/dtpm_bb_monitor.sv
// ---------------------------------------------------------------------------
// dtpm_bb_monitor
//
// Run-time basic-block integrity monitor. It sits behind the DTPM
// precomputed-hash cache in the fetch path. The cache's start/end hit flags
// mark where basic blocks begin and end. Every fetched instruction inside a
// block is folded into a 128-bit running digest. At block end the digest is
// compared with the precomputed hash from the cache, a pass/fail result is
// reported, and a sticky violation flag is kept.
//
// Ports:
//   clk            in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   fetch_valid    in   fetch presented this cycle (qualifies all fetch inputs)
//   fetch_inst     in   fetched instruction word
//   hit_start_addr in   cache: fetch address starts a basic block
//   hit_end_addr   in   cache: fetch address ends a basic block
//   exp_hash       in   cache: precomputed hash (valid with hit_end_addr)
//   cache_index    in   cache: entry index (valid with hit_end_addr)
//   clr_violation  in   clears the sticky violation flag
//   bb_active      out  a basic block is being tracked
//   chk_valid      out  one-cycle pulse, block result available
//   chk_pass       out  block passed (qualified by chk_valid)
//   chk_fail       out  block failed (qualified by chk_valid)
//   err_code       out  00 OK, 01 MISMATCH, 10 UNTERMINATED, 11 OVERFLOW
//   chk_index      out  cache index of the reported block
//   calc_hash      out  computed digest of the reported block
//   inst_count     out  instruction count of the reported block
//   violation      out  sticky, set on any failed block
// ---------------------------------------------------------------------------
module dtpm_bb_monitor #(
  parameter int INST_WIDTH = 32,
  parameter int CNT_W      = 8,
  parameter int MAX_BB_LEN = 200
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fetch_valid,
  input  logic [INST_WIDTH-1:0] fetch_inst,
  input  logic                  hit_start_addr,
  input  logic                  hit_end_addr,
  input  logic [127:0]          exp_hash,
  input  logic [6:0]            cache_index,
  input  logic                  clr_violation,
  output logic                  bb_active,
  output logic                  chk_valid,
  output logic                  chk_pass,
  output logic                  chk_fail,
  output logic [1:0]            err_code,
  output logic [6:0]            chk_index,
  output logic [127:0]          calc_hash,
  output logic [CNT_W-1:0]      inst_count,
  output logic                  violation
);

  typedef enum logic [1:0] {IDLE, TRACK, CHECK} state_t;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISMATCH = 2'b01;
  localparam logic [1:0] ERR_UNTERM   = 2'b10;
  localparam logic [1:0] ERR_OVERFLOW = 2'b11;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BB_LEN);

  state_t           state;
  logic [127:0]     digest;
  logic [CNT_W-1:0] count;
  logic [127:0]     exp_hash_q;
  logic [6:0]       index_q;
  logic             hash_match;
  logic             fail_next;

  // Rotate-left by 32, then XOR the new instruction into the low bits.
  function automatic logic [127:0] fold(input logic [127:0] d,
                                        input logic [INST_WIDTH-1:0] inst);
    return {d[95:0], d[127:96]} ^ {{(128-INST_WIDTH){1'b0}}, inst};
  endfunction

  // Predicts whether the coming edge raises chk_fail, so the sticky flag
  // sets on the same edge and wins over a simultaneous clear.
  always_comb begin
    hash_match = (digest == exp_hash_q);
    fail_next  = 1'b0;
    if (state == CHECK)
      fail_next = !hash_match;
    else if (state == TRACK && fetch_valid && !hit_end_addr)
      fail_next = hit_start_addr || (count == MAX_CNT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      digest     <= '0;
      count      <= '0;
      exp_hash_q <= '0;
      index_q    <= '0;
      bb_active  <= 1'b0;
      chk_valid  <= 1'b0;
      chk_pass   <= 1'b0;
      chk_fail   <= 1'b0;
      err_code   <= ERR_OK;
      chk_index  <= '0;
      calc_hash  <= '0;
      inst_count <= '0;
      violation  <= 1'b0;
    end else begin
      chk_valid <= 1'b0;
      chk_pass  <= 1'b0;
      chk_fail  <= 1'b0;

      if (fail_next)
        violation <= 1'b1;
      else if (clr_violation)
        violation <= 1'b0;

      case (state)
        IDLE: begin
          // Orphan ends and plain fetches are ignored here.
          if (fetch_valid && hit_start_addr) begin
            state     <= TRACK;
            bb_active <= 1'b1;
            digest    <= fold('0, fetch_inst);
            count     <= CNT_W'(1);
          end
        end

        TRACK: begin
          if (fetch_valid) begin
            if (hit_end_addr) begin
              // End has priority over a start hit on the same fetch.
              state      <= CHECK;
              bb_active  <= 1'b0;
              digest     <= fold(digest, fetch_inst);
              count      <= count + CNT_W'(1);
              exp_hash_q <= exp_hash;
              index_q    <= cache_index;
            end else if (hit_start_addr) begin
              // Old block never ended: report it and restart on this fetch.
              chk_valid  <= 1'b1;
              chk_fail   <= 1'b1;
              err_code   <= ERR_UNTERM;
              calc_hash  <= digest;
              inst_count <= count;
              chk_index  <= '0;
              digest     <= fold('0, fetch_inst);
              count      <= CNT_W'(1);
            end else if (count == MAX_CNT) begin
              chk_valid  <= 1'b1;
              chk_fail   <= 1'b1;
              err_code   <= ERR_OVERFLOW;
              calc_hash  <= digest;
              inst_count <= count;
              chk_index  <= '0;
              state      <= IDLE;
              bb_active  <= 1'b0;
              digest     <= '0;
              count      <= '0;
            end else begin
              digest <= fold(digest, fetch_inst);
              count  <= count + CNT_W'(1);
            end
          end
        end

        CHECK: begin
          chk_valid  <= 1'b1;
          chk_pass   <= hash_match;
          chk_fail   <= !hash_match;
          err_code   <= hash_match ? ERR_OK : ERR_MISMATCH;
          calc_hash  <= digest;
          inst_count <= count;
          chk_index  <= index_q;
          // A start hit in this cycle opens the next block back-to-back.
          if (fetch_valid && hit_start_addr) begin
            state     <= TRACK;
            bb_active <= 1'b1;
            digest    <= fold('0, fetch_inst);
            count     <= CNT_W'(1);
          end else begin
            state     <= IDLE;
            bb_active <= 1'b0;
            digest    <= '0;
            count     <= '0;
          end
        end

        default: begin
          state     <= IDLE;
          bb_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtpm_bb_monitor.sv
// ---------------------------------------------------------------------------
// tb_dtpm_bb_monitor
//
// Directed self-checking bench for dtpm_bb_monitor. Each applyStimulus call
// drives one fetch at the falling edge and returns just after the following
// rising edge, so outputs observed afterwards reflect that fetch.
// ---------------------------------------------------------------------------
module tb_dtpm_bb_monitor;

  logic         clk;
  logic         reset_n;
  logic         fetch_valid;
  logic [31:0]  fetch_inst;
  logic         hit_start_addr;
  logic         hit_end_addr;
  logic [127:0] exp_hash;
  logic [6:0]   cache_index;
  logic         clr_violation;
  logic         bb_active;
  logic         chk_valid;
  logic         chk_pass;
  logic         chk_fail;
  logic [1:0]   err_code;
  logic [6:0]   chk_index;
  logic [127:0] calc_hash;
  logic [7:0]   inst_count;
  logic         violation;

  int vecCount  = 0;
  int missCount = 0;

  dtpm_bb_monitor #(
    .INST_WIDTH(32),
    .CNT_W(8),
    .MAX_BB_LEN(200)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .fetch_valid(fetch_valid),
    .fetch_inst(fetch_inst),
    .hit_start_addr(hit_start_addr),
    .hit_end_addr(hit_end_addr),
    .exp_hash(exp_hash),
    .cache_index(cache_index),
    .clr_violation(clr_violation),
    .bb_active(bb_active),
    .chk_valid(chk_valid),
    .chk_pass(chk_pass),
    .chk_fail(chk_fail),
    .err_code(err_code),
    .chk_index(chk_index),
    .calc_hash(calc_hash),
    .inst_count(inst_count),
    .violation(violation)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference fold: rotate-left 32, XOR instruction into the low word.
  function automatic logic [127:0] refFold(input logic [127:0] d, input logic [31:0] inst);
    logic [127:0] r;
    r = {d[95:0], d[127:96]};
    r[31:0] = r[31:0] ^ inst;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] inst,
                               input logic hs, input logic he,
                               input logic [127:0] eh, input logic [6:0] idx,
                               input logic clr);
    @(negedge clk);
    fetch_valid    = v;
    fetch_inst     = inst;
    hit_start_addr = hs;
    hit_end_addr   = he;
    exp_hash       = eh;
    cache_index    = idx;
    clr_violation  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 128'h0, 7'd0, 1'b0);
  endtask

  logic [127:0] expDigest;

  initial begin
    reset_n = 1'b0;
    fetch_valid = 1'b0; fetch_inst = '0; hit_start_addr = 1'b0; hit_end_addr = 1'b0;
    exp_hash = '0; cache_index = '0; clr_violation = 1'b0;
    #12;
    checkOutput("reset_bb_active", 128'(bb_active), 128'd0);
    checkOutput("reset_chk_valid", 128'(chk_valid), 128'd0);
    checkOutput("reset_calc_hash", calc_hash, 128'd0);
    checkOutput("reset_violation", 128'(violation), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Passing two-instruction block.
    applyStimulus(1'b1, 32'h1, 1'b1, 1'b0, 128'h0, 7'd0, 1'b0);
    checkOutput("t1_active", 128'(bb_active), 128'd1);
    applyStimulus(1'b1, 32'h2, 1'b0, 1'b1, 128'h00000000_00000000_00000001_00000002, 7'd5, 1'b0);
    checkOutput("t1_check_cycle_valid", 128'(chk_valid), 128'd0);
    idleCycle();
    checkOutput("t1_valid", 128'(chk_valid), 128'd1);
    checkOutput("t1_pass", 128'(chk_pass), 128'd1);
    checkOutput("t1_fail", 128'(chk_fail), 128'd0);
    checkOutput("t1_err", 128'(err_code), 128'd0);
    checkOutput("t1_count", 128'(inst_count), 128'd2);
    checkOutput("t1_index", 128'(chk_index), 128'd5);
    checkOutput("t1_hash", calc_hash, 128'h00000000_00000000_00000001_00000002);
    checkOutput("t1_violation", 128'(violation), 128'd0);
    idleCycle();
    checkOutput("t1_pulse_end", 128'(chk_valid), 128'd0);

    // Mismatch, sticky violation, clear, and fail-wins-over-clear.
    applyStimulus(1'b1, 32'h1, 1'b1, 1'b0, 128'h0, 7'd0, 1'b0);
    applyStimulus(1'b1, 32'h2, 1'b0, 1'b1, 128'h0, 7'd5, 1'b0);
    idleCycle();
    checkOutput("t2_fail", 128'(chk_fail), 128'd1);
    checkOutput("t2_pass", 128'(chk_pass), 128'd0);
    checkOutput("t2_err", 128'(err_code), 128'd1);
    checkOutput("t2_violation", 128'(violation), 128'd1);
    idleCycle();
    checkOutput("t2_sticky", 128'(violation), 128'd1);
    checkOutput("t2_fail_drop", 128'(chk_fail), 128'd0);
    checkOutput("t2_err_held", 128'(err_code), 128'd1);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 128'h0, 7'd0, 1'b1);
    checkOutput("t2_cleared", 128'(violation), 128'd0);
    applyStimulus(1'b1, 32'h1, 1'b1, 1'b0, 128'h0, 7'd0, 1'b0);
    applyStimulus(1'b1, 32'h2, 1'b0, 1'b1, 128'h0, 7'd5, 1'b0);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 128'h0, 7'd0, 1'b1);
    checkOutput("t2_fail_and_clr", 128'(violation), 128'd1);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 128'h0, 7'd0, 1'b1);
    checkOutput("t2_cleared_again", 128'(violation), 128'd0);

    // Unterminated block restarted by a new start hit.
    applyStimulus(1'b1, 32'hA, 1'b1, 1'b0, 128'h0, 7'd0, 1'b0);
    applyStimulus(1'b1, 32'hB, 1'b0, 1'b0, 128'h0, 7'd0, 1'b0);
    applyStimulus(1'b1, 32'hC, 1'b1, 1'b0, 128'h0, 7'd0, 1'b0);
    checkOutput("t3_valid", 128'(chk_valid), 128'd1);
    checkOutput("t3_fail", 128'(chk_fail), 128'd1);
    checkOutput("t3_err", 128'(err_code), 128'd2);
    checkOutput("t3_hash", calc_hash, {64'h0, 32'hA, 32'hB});
    checkOutput("t3_count", 128'(inst_count), 128'd2);
    checkOutput("t3_index", 128'(chk_index), 128'd0);
    checkOutput("t3_active", 128'(bb_active), 128'd1);
    checkOutput("t3_violation", 128'(violation), 128'd1);
    applyStimulus(1'b1, 32'hD, 1'b0, 1'b1, {64'h0, 32'hC, 32'hD}, 7'd3, 1'b0);
    idleCycle();
    checkOutput("t3_restart_pass", 128'(chk_pass), 128'd1);
    checkOutput("t3_restart_hash", calc_hash, {64'h0, 32'hC, 32'hD});
    checkOutput("t3_restart_index", 128'(chk_index), 128'd3);

    // Overflow: start plus 200 plain fetches with no end.
    applyStimulus(1'b1, 32'h1, 1'b1, 1'b0, 128'h0, 7'd0, 1'b1);
    checkOutput("t4_violation_clr", 128'(violation), 128'd0);
    expDigest = {96'h0, 32'h1};
    for (int k = 1; k <= 200; k++) begin
      applyStimulus(1'b1, 32'(k), 1'b0, 1'b0, 128'h0, 7'd0, 1'b0);
      if (k < 200) expDigest = refFold(expDigest, 32'(k));
      if (k == 199) begin
        checkOutput("t4_no_early_report", 128'(chk_valid), 128'd0);
        checkOutput("t4_still_active", 128'(bb_active), 128'd1);
      end
    end
    checkOutput("t4_valid", 128'(chk_valid), 128'd1);
    checkOutput("t4_fail", 128'(chk_fail), 128'd1);
    checkOutput("t4_err", 128'(err_code), 128'd3);
    checkOutput("t4_count", 128'(inst_count), 128'd200);
    checkOutput("t4_hash", calc_hash, expDigest);
    checkOutput("t4_inactive", 128'(bb_active), 128'd0);
    applyStimulus(1'b1, 32'h5, 1'b0, 1'b0, 128'h0, 7'd0, 1'b0);
    checkOutput("t4_idle_ignores", 128'(bb_active), 128'd0);

    // Back-to-back block opened in the CHECK cycle, gaps mid-block, orphan end.
    applyStimulus(1'b1, 32'h11, 1'b1, 1'b0, 128'h0, 7'd0, 1'b0);
    applyStimulus(1'b1, 32'h12, 1'b0, 1'b1, {64'h0, 32'h11, 32'h12}, 7'd9, 1'b0);
    applyStimulus(1'b1, 32'h21, 1'b1, 1'b1, 128'h0, 7'd0, 1'b0);
    checkOutput("t5_first_pass", 128'(chk_pass), 128'd1);
    checkOutput("t5_first_index", 128'(chk_index), 128'd9);
    checkOutput("t5_b2b_active", 128'(bb_active), 128'd1);
    applyStimulus(1'b0, 32'hFFFF, 1'b1, 1'b1, 128'h0, 7'd1, 1'b0);
    applyStimulus(1'b0, 32'hEEEE, 1'b0, 1'b0, 128'h0, 7'd0, 1'b0);
    checkOutput("t5_gap_no_report", 128'(chk_valid), 128'd0);
    checkOutput("t5_gap_active", 128'(bb_active), 128'd1);
    applyStimulus(1'b1, 32'h22, 1'b0, 1'b1, {64'h0, 32'h21, 32'h22}, 7'd10, 1'b0);
    idleCycle();
    checkOutput("t5_second_pass", 128'(chk_pass), 128'd1);
    checkOutput("t5_second_count", 128'(inst_count), 128'd2);
    checkOutput("t5_second_hash", calc_hash, {64'h0, 32'h21, 32'h22});
    applyStimulus(1'b1, 32'h33, 1'b0, 1'b1, 128'h0, 7'd11, 1'b0);
    idleCycle();
    checkOutput("t5_orphan_no_report", 128'(chk_valid), 128'd0);
    checkOutput("t5_orphan_inactive", 128'(bb_active), 128'd0);
    checkOutput("t5_orphan_index_held", 128'(chk_index), 128'd10);

    // Reset mid-block with violation set.
    applyStimulus(1'b1, 32'h7, 1'b1, 1'b0, 128'h0, 7'd0, 1'b0);
    applyStimulus(1'b1, 32'h8, 1'b1, 1'b0, 128'h0, 7'd0, 1'b0);
    checkOutput("t6_pre_violation", 128'(violation), 128'd1);
    @(negedge clk);
    fetch_valid = 1'b0; hit_start_addr = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("t6_rst_active", 128'(bb_active), 128'd0);
    checkOutput("t6_rst_violation", 128'(violation), 128'd0);
    checkOutput("t6_rst_hash", calc_hash, 128'd0);
    checkOutput("t6_rst_err", 128'(err_code), 128'd0);
    checkOutput("t6_rst_count", 128'(inst_count), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idleCycle();
    checkOutput("t6_no_report", 128'(chk_valid), 128'd0);
    applyStimulus(1'b1, 32'h1, 1'b1, 1'b0, 128'h0, 7'd0, 1'b0);
    applyStimulus(1'b1, 32'h2, 1'b0, 1'b1, {64'h0, 32'h1, 32'h2}, 7'd4, 1'b0);
    idleCycle();
    checkOutput("t6_clean_pass", 128'(chk_pass), 128'd1);
    checkOutput("t6_clean_count", 128'(inst_count), 128'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
